// File: rtl/voltage_telemetry_tx_if.sv
// Sample stream in, UART pin and status out, for the voltage telemetry transmitter.
interface voltage_telemetry_tx_if;
    logic       ena;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       tx;
    logic       tx_busy;
    logic       overrun;

    modport master (
        output ena, sample_in, sample_valid,
        input  tx, tx_busy, overrun
    );

    modport slave (
        input  ena, sample_in, sample_valid,
        output tx, tx_busy, overrun
    );
endinterface

// File: rtl/voltage_telemetry_tx.sv
// Windowed avg/min/max reduction of the voltage byte stream, shipped as a
// 5-byte UART frame {HEADER, avg, min, max, chk} on a single pin.
module voltage_telemetry_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned LOG2_WINDOW  = 3,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    voltage_telemetry_tx_if.slave  bus_if
);
    localparam int unsigned SUM_W      = 8 + LOG2_WINDOW;
    localparam int unsigned CNT_W      = LOG2_WINDOW;
    localparam int unsigned BAUD_W     = 16;
    localparam int unsigned FRAME_W    = 40;
    localparam int unsigned IDX_W      = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(7);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Window accumulators
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [7:0]         min_q, min_d;
    logic [7:0]         max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overrun_q, overrun_d;

    // Transmitter
    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic               accept_c;
    logic               complete_c;
    logic               load_c;
    logic [SUM_W-1:0]   sum_next_c;
    logic [7:0]         min_next_c;
    logic [7:0]         max_next_c;
    logic [7:0]         avg_c;
    logic [7:0]         chk_c;

    // Statistics include the sample being accepted, so a completing sample counts.
    always_comb begin
        accept_c   = bus_if.sample_valid & bus_if.ena;
        sum_next_c = sum_q + SUM_W'(bus_if.sample_in);
        min_next_c = (bus_if.sample_in < min_q) ? bus_if.sample_in : min_q;
        max_next_c = (bus_if.sample_in > max_q) ? bus_if.sample_in : max_q;
        complete_c = accept_c & (&cnt_q);
        avg_c      = 8'(sum_next_c >> LOG2_WINDOW);
        chk_c      = HEADER ^ avg_c ^ min_next_c ^ max_next_c;
        load_c     = complete_c & ~busy_q;

        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q | (complete_c & busy_q);

        if (complete_c) begin
            sum_d = '0;
            min_d = 8'hFF;
            max_d = 8'h00;
            cnt_d = '0;
        end else if (accept_c) begin
            sum_d = sum_next_c;
            min_d = min_next_c;
            max_d = max_next_c;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Frame is a 40-bit right shifter: byte 0 in the low bits, each data bit shifts one out.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (load_c) begin
                    state_d    = ST_START;
                    shift_d    = {chk_c, max_next_c, min_next_c, avg_c, HEADER};
                    baud_d     = '0;
                    byte_idx_d = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ST_START;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            min_q      <= 8'hFF;
            max_q      <= 8'h00;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            min_q      <= min_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus_if.tx      = tx_q;
    assign bus_if.tx_busy = busy_q;
    assign bus_if.overrun = overrun_q;
endmodule

// File: tb/tb_voltage_telemetry_tx.sv
// Scoreboard bench: window model pushes expected frames, a cycle-exact UART monitor pops and checks.
module tb_voltage_telemetry_tx;
    localparam int unsigned CPB       = 16;
    localparam int unsigned LW        = 3;
    localparam int unsigned WIN       = 1 << LW;
    localparam logic [7:0]  HDR       = 8'hA5;
    localparam longint      FRAME_CYC = 50 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    voltage_telemetry_tx_if bus();

    voltage_telemetry_tx #(
        .CLKS_PER_BIT (CPB),
        .LOG2_WINDOW  (LW),
        .HEADER       (HDR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint      start;
        logic [39:0] bytes;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] win_q[$];
    longint     busy_last = -1;
    bit         ovr_set   = 1'b0;
    longint     ovr_cycle = 0;
    int         checks    = 0;
    int         errors    = 0;

    bit          in_frame  = 1'b0;
    longint      fstart    = 0;
    frame_t      cur;
    int          byte_bad  = 0;
    int          busy_bad  = 0;
    int          ovr_bad   = 0;
    logic [7:0]  rx_byte   = 8'h00;
    logic [39:0] rx_frame  = '0;
    logic [39:0] last_rx   = '0;
    int          frames_rx = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: a window of WIN accepted samples becomes one frame unless a frame is still on the wire.
    task automatic model_accept(input logic [7:0] s);
        int unsigned sum;
        int unsigned mn;
        int unsigned mx;
        logic [7:0]  avg;
        logic [7:0]  chk;
        win_q.push_back(s);
        if (win_q.size() == WIN) begin
            sum = 0;
            mn  = 255;
            mx  = 0;
            foreach (win_q[i]) begin
                sum += 32'(win_q[i]);
                if (32'(win_q[i]) < mn) mn = 32'(win_q[i]);
                if (32'(win_q[i]) > mx) mx = 32'(win_q[i]);
            end
            avg = 8'(sum / WIN);
            chk = HDR ^ avg ^ 8'(mn) ^ 8'(mx);
            if (cyc <= busy_last) begin
                if (!ovr_set) begin
                    ovr_set   = 1'b1;
                    ovr_cycle = cyc;
                end
            end else begin
                exp_q.push_back('{cyc + 1, {chk, 8'(mx), 8'(mn), avg, HDR}});
                busy_last = cyc + FRAME_CYC;
            end
            win_q.delete();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        win_q.delete();
        busy_last = -1;
        ovr_set   = 1'b0;
        ovr_cycle = 0;
    endtask

    // Called at a falling edge; inputs apply to the cycle that ends at the next rising edge.
    task automatic drive(input logic v, input logic e, input logic [7:0] s);
        bus.sample_valid = v;
        bus.ena          = e;
        bus.sample_in    = s;
        if (v && e) model_accept(s);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame || cyc <= busy_last + 2) && n < 4000) begin
            drive(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("idle_reached", 64'(n < 4000), 64'(1));
    endtask

    // Monitor: every frame cycle must carry the level the expected frame dictates.
    always @(negedge clk) begin : mon_p
        longint pos;
        int     b;
        int     w;
        int     j;
        int     k;
        logic   lvl;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (bus.overrun !== (ovr_set && cyc > ovr_cycle)) ovr_bad++;
            if (!in_frame) begin
                if (exp_q.size() > 0 && cyc > exp_q[0].start) begin
                    check("frame_present", 64'(0), 64'(1));
                    void'(exp_q.pop_front());
                end else if (bus.tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame_start", 64'(1), 64'(0));
                        cur = '{cyc, 40'h0};
                    end else begin
                        cur = exp_q.pop_front();
                        check("frame_start_cycle", 64'(cyc), 64'(cur.start));
                    end
                    in_frame = 1'b1;
                    fstart   = cyc;
                    byte_bad = 0;
                    busy_bad = 0;
                end
            end
            if (in_frame) begin
                pos = cyc - fstart;
                if (pos < FRAME_CYC) begin
                    b = int'(pos / longint'(CPB));
                    w = int'(pos % longint'(CPB));
                    j = b / 10;
                    k = b % 10;
                    if (k == 0)      lvl = 1'b0;
                    else if (k == 9) lvl = 1'b1;
                    else             lvl = cur.bytes[j*8 + k - 1];
                    if (bus.tx !== lvl) byte_bad++;
                    if (bus.tx_busy !== 1'b1) busy_bad++;
                    if (k >= 1 && k <= 8 && w == int'(CPB / 2)) rx_byte[k-1] = bus.tx;
                    if (k == 9 && w == int'(CPB) - 1) begin
                        check($sformatf("frame_byte%0d", j), 64'(rx_byte), 64'(cur.bytes[j*8 +: 8]));
                        check($sformatf("byte%0d_bit_timing_bad_cycles", j), 64'(byte_bad), 64'(0));
                        rx_frame[j*8 +: 8] = rx_byte;
                        byte_bad = 0;
                    end
                end else begin
                    check("busy_low_cycles_in_frame", 64'(busy_bad), 64'(0));
                    check("busy_after_frame", 64'(bus.tx_busy), 64'(0));
                    check("overrun_bad_cycles", 64'(ovr_bad), 64'(0));
                    ovr_bad   = 0;
                    last_rx   = rx_frame;
                    frames_rx++;
                    in_frame  = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog_p
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim_p
        int fr0;
        int n;
        rst_n            = 1'b0;
        bus.ena          = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(bus.tx), 64'(1));
        check("reset_busy", 64'(bus.tx_busy), 64'(0));
        check("reset_overrun", 64'(bus.overrun), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed windows with hand-computed frames
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(i * 10));
        wait_idle();
        check("frame_ramp", 64'(last_rx), 64'(40'hD2_50_0A_2D_A5));

        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h07);
        wait_idle();
        check("frame_truncated_avg", 64'(last_rx), 64'(40'hA2_07_00_00_A5));

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'hFF);
        wait_idle();
        check("frame_all_ff", 64'(last_rx), 64'(40'h5A_FF_FF_FF_A5));

        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(i));
        wait_idle();
        check("frame_after_ff", 64'(last_rx), 64'(40'hA8_08_01_04_A5));

        // Back-to-back windows: second is dropped while the first is on the wire
        check("overrun_before_drop", 64'(bus.overrun), 64'(0));
        fr0 = frames_rx;
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 8'($urandom));
        check("overrun_not_early", 64'(bus.overrun), 64'(0));
        drive(1'b1, 1'b1, 8'($urandom));
        check("overrun_rise", 64'(bus.overrun), 64'(1));
        wait_idle();
        check("overrun_sticky", 64'(bus.overrun), 64'(1));
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'($urandom));
        wait_idle();
        check("frames_after_drop", 64'(frames_rx - fr0), 64'(2));

        // ena gating, then ena toggling while a frame is in flight
        fr0 = frames_rx;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'(i % 2), 8'($urandom));
        for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        wait_idle();
        check("ena_gated_frame_sent", 64'(frames_rx > fr0), 64'(1));

        // Random traffic
        for (int i = 0; i < 4000; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 8'($urandom));
        wait_idle();

        // Reset in the middle of the data bits
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'($urandom));
        n = 0;
        while (!(in_frame && (cyc - fstart) >= longint'(3 * CPB + 5)) && n < 2000) begin
            drive(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("reached_mid_data", 64'(n < 2000), 64'(1));
        check("overrun_pre_reset", 64'(bus.overrun), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", 64'(bus.tx), 64'(1));
        check("async_reset_busy", 64'(bus.tx_busy), 64'(0));
        check("async_reset_overrun", 64'(bus.overrun), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fr0 = frames_rx;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'($urandom));
        wait_idle();
        check("frame_after_reset", 64'(frames_rx - fr0), 64'(1));
        check("final_overrun", 64'(bus.overrun), 64'(0));
        check("pending_frames", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
